// File: rtl/processing_element_pipe.sv
// Systolic multiply-accumulate cell: forwards operands and beat qualifiers to neighbours,
// accumulates tile products (saturating or wrapping) and holds the tile result for a consumer.
module processing_element_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned SAT_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              mode_signed,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_clear,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_valid,
  output logic              out_clear,
  output logic              out_last,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_ovf,
  output logic              res_overrun
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  if (ACC_W < 2 * DATA_W) begin : g_param_check
    $error("processing_element_pipe: ACC_W must be at least 2*DATA_W");
  end

  logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic              out_valid_q, out_valid_d, out_clear_q, out_clear_d;
  logic              out_last_q, out_last_d;
  logic [ACC_W-1:0]  acc_q, acc_d, res_data_q, res_data_d;
  logic              tile_ovf_q, tile_ovf_d;
  logic              res_valid_q, res_valid_d, res_ovf_q, res_ovf_d;
  logic              res_overrun_q, res_overrun_d;

  logic                     fire;
  logic                     capture;
  logic signed [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0]        prod_u;
  logic [SUM_W-1:0]         prod_ext;
  logic [SUM_W-1:0]         base;
  logic [SUM_W-1:0]         sum;
  logic                     ovf;
  logic [ACC_W-1:0]         sat_val;
  logic [ACC_W-1:0]         acc_new;
  logic                     tile_new;

  always_comb begin
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_valid_d   = out_valid_q;
    out_clear_d   = out_clear_q;
    out_last_d    = out_last_q;
    acc_d         = acc_q;
    tile_ovf_d    = tile_ovf_q;
    res_data_d    = res_data_q;
    res_ovf_d     = res_ovf_q;
    res_valid_d   = res_valid_q;
    res_overrun_d = res_overrun_q;

    fire    = in_valid && !stall;
    capture = fire && in_last;

    // Operands are extended before the multiply so the full-width product is kept.
    prod_s = PROD_W'($signed(in_a)) * PROD_W'($signed(in_b));
    prod_u = PROD_W'(in_a) * PROD_W'(in_b);

    // One guard bit above ACC_W is enough to hold any acc + product without loss.
    if (mode_signed) begin
      prod_ext = SUM_W'(prod_s);
      base     = SUM_W'($signed(acc_q));
    end else begin
      prod_ext = SUM_W'(prod_u);
      base     = SUM_W'(acc_q);
    end
    if (in_clear) begin
      base = '0;
    end
    sum = base + prod_ext;

    if (mode_signed) begin
      ovf     = sum[ACC_W] ^ sum[ACC_W-1];
      sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf     = sum[ACC_W];
      sat_val = '1;
    end
    acc_new  = (ovf && (SAT_EN != 0)) ? sat_val : sum[ACC_W-1:0];
    tile_new = in_clear ? ovf : (tile_ovf_q | ovf);

    if (!stall) begin
      out_a_d     = in_a;
      out_b_d     = in_b;
      out_valid_d = in_valid;
      out_clear_d = in_clear;
      out_last_d  = in_last;
    end

    if (fire) begin
      acc_d      = acc_new;
      tile_ovf_d = tile_new;
    end

    // Result slot: a capture always wins; overwriting an unconsumed result is sticky.
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    if (capture) begin
      res_data_d  = acc_new;
      res_ovf_d   = tile_new;
      res_valid_d = 1'b1;
      if (res_valid_q && !res_ready) begin
        res_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_clear_q   <= 1'b0;
      out_last_q    <= 1'b0;
      acc_q         <= '0;
      tile_ovf_q    <= 1'b0;
      res_data_q    <= '0;
      res_ovf_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_overrun_q <= 1'b0;
    end else begin
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_valid_q   <= out_valid_d;
      out_clear_q   <= out_clear_d;
      out_last_q    <= out_last_d;
      acc_q         <= acc_d;
      tile_ovf_q    <= tile_ovf_d;
      res_data_q    <= res_data_d;
      res_ovf_q     <= res_ovf_d;
      res_valid_q   <= res_valid_d;
      res_overrun_q <= res_overrun_d;
    end
  end

  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_valid   = out_valid_q;
  assign out_clear   = out_clear_q;
  assign out_last    = out_last_q;
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign res_ovf     = res_ovf_q;
  assign res_overrun = res_overrun_q;

endmodule

// File: doc/processing_element_pipe.md
PROCESSING_ELEMENT_PIPE -- requirements
Module: processing_element_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8: operand width in bits.
REQ-002 SHALL have parameter ACC_W, default 32: accumulator/result width; elaboration SHALL fail if ACC_W < 2*DATA_W.
REQ-003 SHALL have parameter SAT_EN, default 1: 1 = saturating accumulate, 0 = modulo-2^ACC_W wrap.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 stall  in  1  1 = freeze operand path and accumulator.
REQ-007 mode_signed  in  1  1 = signed two's-complement operands/accumulator, 0 = unsigned; sampled per beat.
REQ-008 in_valid  in  1  operand beat valid.
REQ-009 in_a, in_b  in  DATA_W each  operands.
REQ-010 in_clear  in  1  beat is first of a tile: accumulator restarts at 0.
REQ-011 in_last  in  1  beat is last of a tile: result is captured.
REQ-012 out_a, out_b  out  DATA_W each  registered copies of in_a/in_b for the right/lower neighbour.
REQ-013 out_valid, out_clear, out_last  out  1 each  registered copies of beat qualifiers.
REQ-014 res_data  out  ACC_W  captured tile result.
REQ-015 res_valid  out  1  res_data holds an unconsumed result.
REQ-016 res_ready  in  1  consumer accepts result when res_valid=1.
REQ-017 res_ovf  out  1  captured tile overflowed/saturated at least once.
REQ-018 res_overrun  out  1  sticky: an unconsumed result was overwritten.

Function
REQ-019 Beat fires when in_valid=1 and stall=0; fields with in_valid=0 SHALL be ignored, including in_clear/in_last.
REQ-020 On every edge with stall=0, out_a/out_b/out_valid/out_clear/out_last SHALL load in_a/in_b/in_valid/in_clear/in_last (1-cycle latency); with stall=1 they SHALL hold.
REQ-021 Product SHALL be 2*DATA_W bits, signed or unsigned per mode_signed, extended to ACC_W+1 bits.
REQ-022 On fired beat: sum = (in_clear ? 0 : acc) + product; acc SHALL load the clamped/wrapped sum the same edge.
REQ-023 Signed: overflow when sum > 2^(ACC_W-1)-1 or < -2^(ACC_W-1); SAT_EN=1 clamps to the limit, SAT_EN=0 wraps.
REQ-024 Unsigned: overflow when sum > 2^ACC_W-1; SAT_EN=1 clamps to all-ones, SAT_EN=0 wraps.
REQ-025 Tile overflow flag SHALL be set on any overflowing beat, and set to that beat's overflow status on an in_clear beat.
REQ-026 On fired beat with in_last=1, res_data SHALL load the new acc value and res_ovf the new tile flag on the same edge; res_valid=1 next cycle (result latency 1 cycle after last beat).
REQ-027 in_clear and in_last on the same beat SHALL form a single-product tile.
REQ-028 res_valid SHALL clear on the edge where res_valid=1 and res_ready=1, unless a capture occurs that edge.
REQ-029 Capture with res_valid=1 and res_ready=1 on the same edge: new result loads, res_valid stays 1, no overrun.
REQ-030 Capture with res_valid=1 and res_ready=0: new result overwrites, res_overrun SHALL set and hold until reset.
REQ-031 Result handshake SHALL operate independently of stall.
REQ-032 A beat without in_clear after reset SHALL accumulate onto acc=0.

Reset
REQ-033 While reset=1, at each edge, all outputs, acc and tile flag SHALL go to 0, overriding stall and any fired beat; reset mid-tile SHALL discard the partial sum.

Verification
REQ-034 Defaults, signed; beats (3,4,clear),(-2,5),(7,1,last) -> res_data=9 one cycle after last beat; res_valid=1; res_ovf=0.
REQ-035 ACC_W=16, SAT_EN=1, signed; three beats 127*127 -> 16129, 32258, then 32767; res_ovf=1; SAT_EN=0 same stimulus -> res_data=-17149 (48387-65536), res_ovf=1.
REQ-036 ACC_W=16, unsigned; 255*255 twice -> 65025 then 65535 clamped; signed same bits (-1*-1 twice) -> 2.
REQ-037 stall=1 for 3 cycles mid-tile with in_valid=1 -> acc and out_* frozen, stalled beats not counted; res handshake still drains a held result.
REQ-038 Two 1-beat tiles (2*3, 4*5) back-to-back with res_ready=0 -> res_data=20, res_overrun=1; repeat with res_ready=1 on second capture edge -> res_data=20, res_valid=1, res_overrun=0.
REQ-039 reset=1 for one cycle after two beats of a tile -> all outputs 0; next beat 6*7 with last, no clear -> res_data=42.
